cond_flag_unit: RTL
===================

Name: cond_flag_unit

Overview:
- Parametrised successor to the combinational condition checker.
- Owns the architectural status register {Z,C,N,V}.
- Tracks in-flight flag-setting instructions and evaluates ARM condition codes for NUM_CH issue slots per cycle, with a ready/valid handshake and a registered result.
- Sits between decode/issue and the execute/write-back stages.

Parameters:
- NUM_CH, 2: condition queries evaluated per cycle; slot 0 is oldest.
- PENDING_MAX, 3: maximum in-flight flag-setting instructions tracked.
- BYPASS, 1: 1 evaluates against write-back flags in the same cycle they arrive; 0 evaluates only against the registered SR.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; discards pending tracking and this cycle's acceptances.
- q_valid  in  NUM_CH  query present per slot.
- q_cond  in  4*NUM_CH  condition code per slot; slot i is bits [4i+3:4i].
- q_set  in  NUM_CH  queried instruction will write flags (S bit).
- q_ready  out  NUM_CH  slot may be accepted this cycle.
- wb_valid  in  1  flag write-back strobe.
- wb_flags  in  4  write-back flags {Z,C,N,V}, bit3..0.
- res_valid  out  NUM_CH  registered: slot accepted in the previous cycle.
- res_state  out  NUM_CH  registered: condition passed.
- status  out  4  current SR {Z,C,N,V}.
- pending  out  clog2(PENDING_MAX+1)  in-flight flag-setter count.
- err_underflow  out  1  sticky: write-back arrived with pending==0.

Behaviour:
- Reset (async, rst_n=0): SR=0, pending=0, res_valid=0, res_state=0, err_underflow=0.
- Condition encoding and evaluation:
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C&~Z
  - 9 LS: ~C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: ~Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- Effective flags F = (BYPASS && wb_valid) ? wb_flags : SR.
- Dependence rule:
  - Cond 14 and 15 are flag-independent.
  - Every other cond is flag-dependent.
- Per-slot ready, evaluated in slot order i=0..NUM_CH-1:
  - Define blocked = (pending_eff != 0) OR (some older slot k<i has q_valid&q_ready&q_set this cycle).
  - pending_eff = pending - (BYPASS && wb_valid && pending!=0 ? 1 : 0).
  - q_ready[i] = 0 if flush.
  - q_ready[i] = 0 if the slot is flag-dependent and blocked.
  - q_ready[i] = 0 if q_set[i] and (pending + older accepted sets in this cycle) == PENDING_MAX, counting a same-cycle write-back as freeing a slot.
  - q_ready[i] = 0 if any older slot k<i has q_valid & ~q_ready; slots accept in order.
  - Otherwise q_ready[i] = 1.
- Accept: q_valid[i]&q_ready[i]. At the next edge, res_valid[i]=1 and res_state[i]=eval(q_cond_i, F sampled in the accept cycle). Latency is 1 cycle.
- Non-accepted slot: res_valid[i]=0 next cycle; res_state[i] holds its previous value.
- SR update: wb_valid=1 gives SR<=wb_flags at the edge, regardless of flush.
- Pending counter: pending <= pending + accepted_sets - (wb_valid && pending!=0).
  - Never exceeds PENDING_MAX.
  - Never wraps below 0.
- wb_valid with pending==0: SR still updated, counter stays 0, err_underflow<=1. err_underflow clears only on reset.
- Flush: pending<=0 and no acceptances (res_valid all 0 next cycle). A simultaneous wb_valid still updates SR and does not set err_underflow.
- Reset mid-operation: all state returns to reset values immediately; the in-flight result is lost.

Decomposition:
- Shared package/header (constants.h) holds:
  - condition-code localparams EQ..NV, 4-bit;
  - SR bit indices Z=3, C=2, N=1, V=0.
- One natural sub-module: cond_eval, a pure combinational (cond, flags)->state function. It is instantiated NUM_CH times.
- Ready chain, counter, SR and result registers live in the top.

Test Plan:
- Reset: rst_n=0 mid-cycle with pending=2 -> immediately SR=0, pending=0, res_valid=0, err_underflow=0.
- All 16 conds against SR=4'b1000 (Z=1) -> next cycle, res_state: EQ=1, NE=0, LS=1, HI=0, GE=1, GT=0, LE=1, AL=1, NV=0.
- Issue set-flag instruction on slot0 plus EQ on slot1 in the same cycle:
  - q_ready=2'b01, pending becomes 1.
  - Next cycle EQ is stalled.
  - wb_valid with wb_flags=4'b0000 and BYPASS=1 -> EQ accepted that cycle, res_state=0, pending=0.
- Same sequence with BYPASS=0 -> EQ accepted one cycle after write-back.
- Fill pending to PENDING_MAX=3 -> a further q_set query has q_ready=0; an AL query without q_set is accepted; counter holds 3.
- wb_valid with pending=0 and wb_flags=4'b0110 -> status=4'b0110, err_underflow=1 and stays 1.
- Flush with pending=2 and wb_valid=1 -> pending=0, res_valid=0 next cycle, SR updated.

Source files
------------

// File: rtl/cond_flag_unit_pkg.sv
// Shared condition-code encodings and status-register bit positions for the flag unit.
package cond_flag_unit_pkg;

  localparam logic [3:0] CondEq = 4'd0;
  localparam logic [3:0] CondNe = 4'd1;
  localparam logic [3:0] CondCs = 4'd2;
  localparam logic [3:0] CondCc = 4'd3;
  localparam logic [3:0] CondMi = 4'd4;
  localparam logic [3:0] CondPl = 4'd5;
  localparam logic [3:0] CondVs = 4'd6;
  localparam logic [3:0] CondVc = 4'd7;
  localparam logic [3:0] CondHi = 4'd8;
  localparam logic [3:0] CondLs = 4'd9;
  localparam logic [3:0] CondGe = 4'd10;
  localparam logic [3:0] CondLt = 4'd11;
  localparam logic [3:0] CondGt = 4'd12;
  localparam logic [3:0] CondLe = 4'd13;
  localparam logic [3:0] CondAl = 4'd14;
  localparam logic [3:0] CondNv = 4'd15;

  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagV = 0;

  // AL and NV resolve without looking at the flags, so they never wait on a setter.
  function automatic logic cond_uses_flags(input logic [3:0] cond);
    return (cond != CondAl) && (cond != CondNv);
  endfunction

endpackage

// File: rtl/cond_flag_unit_eval.sv
// Pure combinational ARM condition-code evaluation against a {Z,C,N,V} flag vector.
module cond_eval
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       state
);

  logic z, c, n, v;

  assign z = flags[FlagZ];
  assign c = flags[FlagC];
  assign n = flags[FlagN];
  assign v = flags[FlagV];

  always_comb begin
    state = 1'b0;
    unique case (cond)
      CondEq: state = z;
      CondNe: state = ~z;
      CondCs: state = c;
      CondCc: state = ~c;
      CondMi: state = n;
      CondPl: state = ~n;
      CondVs: state = v;
      CondVc: state = ~v;
      CondHi: state = c & ~z;
      CondLs: state = ~c | z;
      CondGe: state = (n == v);
      CondLt: state = (n != v);
      CondGt: state = ~z & (n == v);
      CondLe: state = z | (n != v);
      CondAl: state = 1'b1;
      CondNv: state = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Status register owner: tracks in-flight flag setters, gates condition queries in order and
// registers per-slot condition results one cycle after acceptance.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter int unsigned  NUM_CH      = 2,
  parameter int unsigned  PENDING_MAX = 3,
  parameter bit           BYPASS      = 1'b1,
  localparam int unsigned PW          = $clog2(PENDING_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_CH-1:0]     q_valid,
  input  logic [4*NUM_CH-1:0]   q_cond,
  input  logic [NUM_CH-1:0]     q_set,
  output logic [NUM_CH-1:0]     q_ready,
  input  logic                  wb_valid,
  input  logic [3:0]            wb_flags,
  output logic [NUM_CH-1:0]     res_valid,
  output logic [NUM_CH-1:0]     res_state,
  output logic [3:0]            status,
  output logic [PW-1:0]         pending,
  output logic                  err_underflow
);

  logic [3:0]        sr_q;
  logic [PW-1:0]     pending_q, pending_d, pend_free, pend_byp;
  logic [NUM_CH-1:0] res_valid_q, res_state_q, accept, eval_state;
  logic              err_q, wb_dec;
  logic [3:0]        flags_eff;
  int unsigned       sets_acc;
  logic              stall, dep, blocked, full;

  assign wb_dec    = wb_valid && (pending_q != '0);
  assign flags_eff = (BYPASS && wb_valid) ? wb_flags : sr_q;
  // Capacity always credits a retiring setter; dependence only does when its flags are forwarded.
  assign pend_free = pending_q - PW'(wb_dec);
  assign pend_byp  = BYPASS ? pend_free : pending_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_eval
    cond_eval u_cond_eval (
      .cond  (q_cond[4*g +: 4]),
      .flags (flags_eff),
      .state (eval_state[g])
    );
  end

  always_comb begin
    sets_acc = 0;
    stall    = 1'b0;
    dep      = 1'b0;
    blocked  = 1'b0;
    full     = 1'b0;
    q_ready  = '0;
    accept   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dep        = cond_uses_flags(q_cond[4*i +: 4]);
      blocked    = (pend_byp != '0) || (sets_acc != 0);
      full       = q_set[i] && ((32'(pend_free) + sets_acc) >= PENDING_MAX);
      q_ready[i] = !flush && !(dep && blocked) && !full && !stall;
      accept[i]  = q_valid[i] && q_ready[i];
      if (accept[i] && q_set[i]) sets_acc = sets_acc + 1;
      // A stalled older slot holds back every younger one.
      if (q_valid[i] && !q_ready[i]) stall = 1'b1;
    end
    pending_d = flush ? '0 : PW'(32'(pend_free) + sets_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      pending_q   <= '0;
      res_valid_q <= '0;
      res_state_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (wb_valid) sr_q <= wb_flags;
      pending_q   <= pending_d;
      res_valid_q <= accept;
      res_state_q <= (accept & eval_state) | (~accept & res_state_q);
      if (wb_valid && (pending_q == '0) && !flush) err_q <= 1'b1;
    end
  end

  assign res_valid     = res_valid_q;
  assign res_state     = res_state_q;
  assign status        = sr_q;
  assign pending       = pending_q;
  assign err_underflow = err_q;

endmodule
